// File: rtl/key_store_bank.sv
// Multi-slot key store: word-serial loads into a staging buffer, atomic slot commit,
// sticky per-slot locks, a zeroize sweep and registered, checked reads.
module key_store_bank #(
    parameter int  KEY_WIDTH  = 128,
    parameter int  WORD_WIDTH = 32,
    parameter int  NUM_SLOTS  = 4,
    localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_start,
    input  logic [SLOT_W-1:0]     ld_slot,
    input  logic                  ld_valid,
    input  logic [WORD_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  ld_err,
    input  logic                  lock_req,
    input  logic [SLOT_W-1:0]     lock_slot,
    input  logic                  zeroize,
    output logic                  busy,
    input  logic                  rd_req,
    input  logic [SLOT_W-1:0]     rd_slot,
    output logic [KEY_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic [NUM_SLOTS-1:0]  slot_valid,
    output logic [NUM_SLOTS-1:0]  slot_locked
);
    localparam int NWORDS = KEY_WIDTH / WORD_WIDTH;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NWORDS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ZERO} state_t;
    state_t state, state_next;

    logic [KEY_WIDTH-1:0] keys [NUM_SLOTS];
    logic [KEY_WIDTH-1:0] staging, staging_next;
    logic [CNT_W-1:0]     cnt;
    logic [SLOT_W-1:0]    tgt;
    logic [SLOT_W-1:0]    zcnt;
    logic start_ok, start_bad, accept, commit, discard, enter_zero;
    logic tgt_locked, rd_ok;

    function automatic logic in_range(input logic [SLOT_W-1:0] s);
        return 32'(s) < NUM_SLOTS;
    endfunction

    // A lock arriving in the same cycle as the last word also wins over the commit.
    assign tgt_locked = slot_locked[tgt] | (lock_req && lock_slot == tgt);
    assign rd_ok      = in_range(rd_slot) && slot_valid[rd_slot] && state != ZERO;
    assign ld_ready   = (state == LOAD);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        discard    = 1'b0;
        enter_zero = 1'b0;
        case (state)
            IDLE: begin
                if (zeroize) begin
                    state_next = ZERO;
                    enter_zero = 1'b1;
                end else if (ld_start) begin
                    if (!in_range(ld_slot) || slot_locked[ld_slot]) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (zeroize) begin
                    state_next = ZERO;
                    enter_zero = 1'b1;
                end else if (ld_valid) begin
                    accept = 1'b1;
                    if (cnt == LAST_WORD) begin
                        state_next = IDLE;
                        if (tgt_locked) discard = 1'b1;
                        else            commit  = 1'b1;
                    end
                end
            end
            ZERO: begin
                if (zcnt == LAST_SLOT) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word k lands MSB-first; the committed key includes the word accepted this cycle.
    always_comb begin
        staging_next = staging;
        for (int k = 0; k < NWORDS; k++) begin
            if (cnt == CNT_W'(k)) staging_next[KEY_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) keys[i] <= '0;
            staging     <= '0;
            cnt         <= '0;
            tgt         <= '0;
            zcnt        <= '0;
            slot_valid  <= '0;
            slot_locked <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_err      <= 1'b0;
            ld_done     <= 1'b0;
            ld_err      <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
            if (start_ok) begin
                tgt <= ld_slot;
                cnt <= '0;
            end
            if (start_bad) ld_err <= 1'b1;
            if (accept) begin
                staging <= staging_next;
                cnt     <= cnt + 1'b1;
            end
            if (commit) begin
                keys[tgt]       <= staging_next;
                slot_valid[tgt] <= 1'b1;
                ld_done         <= 1'b1;
            end
            if (discard) ld_err <= 1'b1;
            if (commit || discard || enter_zero) begin
                staging <= '0;
                cnt     <= '0;
            end
            if (enter_zero) zcnt <= '0;
            if (state == ZERO) begin
                keys[zcnt]       <= '0;
                slot_valid[zcnt] <= 1'b0;
                zcnt             <= zcnt + 1'b1;
            end
            if (lock_req && in_range(lock_slot)) slot_locked[lock_slot] <= 1'b1;
            rd_valid <= rd_req;
            rd_err   <= rd_req && !rd_ok;
            if (rd_req) rd_data <= rd_ok ? keys[rd_slot] : '0;
        end
    end
endmodule

// File: doc/key_store_bank.md
Name: key_store_bank

Overview:
- Parametrised multi-slot key store for the PMU bitstream-decryption path.
- Keys load one word at a time over a valid/ready handshake into a staging buffer; a slot updates atomically only after its last word.
- Each slot has a valid flag and a sticky lock. A global zeroize sweep clears all key material. Reads are registered and checked.

Parameters:
- KEY_WIDTH, 128, bits per key; must be an integer multiple of WORD_WIDTH.
- WORD_WIDTH, 32, load-bus width.
- NUM_SLOTS, 4, number of key slots (>=2).
- Derived: NWORDS = KEY_WIDTH/WORD_WIDTH; SLOT_W = max(1, clog2(NUM_SLOTS)).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- ld_start  in  1  begin a load into ld_slot; accepted in IDLE only.
- ld_slot  in  SLOT_W  target slot, sampled with ld_start.
- ld_valid  in  1  load word present.
- ld_data  in  WORD_WIDTH  load word; the first word is the MSB word.
- ld_ready  out  1  high in LOAD state only.
- ld_done  out  1  one-cycle pulse when a key commits.
- ld_err  out  1  one-cycle pulse when a load is rejected or discarded.
- lock_req  in  1  set the lock bit of lock_slot.
- lock_slot  in  SLOT_W  slot to lock.
- zeroize  in  1  start the zeroize sweep; level or pulse.
- busy  out  1  high in LOAD or ZERO.
- rd_req  in  1  read request.
- rd_slot  in  SLOT_W  slot to read.
- rd_data  out  KEY_WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse, one cycle after rd_req.
- rd_err  out  1  qualifies rd_valid; read refused and rd_data = 0.
- slot_valid  out  NUM_SLOTS  per-slot key-present flags.
- slot_locked  out  NUM_SLOTS  per-slot lock flags.

Behaviour:
- Reset (rst=0, asynchronous):
  - All key slots, staging buffer, word counter, slot_valid, slot_locked, rd_data, rd_valid, rd_err, ld_done and ld_err go to 0.
  - FSM goes to IDLE. ld_ready=0, busy=0.
  - Reset asserted mid-load or mid-sweep aborts immediately; no partial state survives.
- FSM states: IDLE, LOAD, ZERO.
- IDLE:
  - zeroize=1 -> ZERO. zeroize has priority over ld_start in the same cycle.
  - Else ld_start=1:
    - If the slot is locked or ld_slot >= NUM_SLOTS: pulse ld_err next cycle, stay IDLE.
    - Otherwise latch the slot, clear the word counter, go to LOAD.
- LOAD:
  - ld_ready=1. A word is accepted when ld_valid && ld_ready.
  - Word k goes into staging bits [KEY_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH]. The counter increments on each accepted word.
  - On acceptance of word NWORDS-1:
    - If the target slot is still unlocked: the next edge writes the staging buffer to the slot, sets slot_valid, pulses ld_done, and returns to IDLE.
    - If a lock landed during the load: the data is discarded, ld_err pulses, slot contents are unchanged, and the FSM returns to IDLE.
  - ld_start is ignored while in LOAD.
  - zeroize in LOAD aborts the load, clears staging and the counter, and goes to ZERO; no ld_done or ld_err.
  - No timeout: LOAD waits indefinitely for ld_valid.
- ZERO:
  - Clears one slot per cycle in ascending index order, clearing both the key and its slot_valid bit.
  - Staging is cleared on entry.
  - After slot NUM_SLOTS-1 is cleared: go to IDLE. Total time in ZERO is NUM_SLOTS cycles.
  - slot_locked is not cleared, so a locked slot remains unloadable until reset.
  - zeroize held high re-enters ZERO after returning to IDLE.
- Lock:
  - lock_req sets slot_locked[lock_slot] on the next edge, in any state.
  - Out-of-range lock_slot is ignored.
  - Locks clear only on reset.
  - A locked slot stays readable if valid.
- Read (registered, latency 1, any state):
  - Next cycle rd_valid=1.
  - If the slot is valid, in range, and the FSM is not in ZERO: rd_data = slot key, rd_err=0.
  - Otherwise rd_data = 0, rd_err=1.
  - A read in the same cycle as a commit to that slot returns the pre-commit value.
  - rd_data holds its value between reads.
- Staging contents are never visible on any output.

Test Plan:
- Reset, then load slot 2 with words 0x01234567, 0x89ABCDEF, 0xDEADBEEF, 0x0BADF00D (ld_valid held) -> ld_ready for 4 cycles, ld_done pulse, slot_valid=4'b0100. Reading slot 2 gives 128'h0123456789ABCDEFDEADBEEF0BADF00D, rd_err=0. Reading slot 1 gives rd_data=0, rd_err=1.
- Load with ld_valid gapped (valid 1,0,0,1,1,0,1) -> exactly 4 words captured in order; result identical to the gap-free load; no early commit.
- Lock slot 2 after loading it, then ld_start to slot 2 -> ld_err pulse, stays IDLE, key unchanged. lock_req on slot 0 while slot 0 is mid-load (after word 2) -> ld_err at word 4, slot_valid[0]=0.
- Load slots 0 and 1, assert zeroize while slot 3 is mid-load -> load aborted, busy for 4 cycles, then slot_valid=0 and all reads rd_err=1. slot_locked is retained and ld_done never pulses.
- Assert rst low mid-load (after word 3) and mid-zeroize -> all outputs read 0 asynchronously. After release, the FSM is in IDLE, all slots are empty, and a fresh load succeeds.
